// File: rtl/rr_arb8.sv
// Round-robin scheduler for an 8:1 word mux: registered one-hot grant and select, valid/ready beat handshake.
// Optional macro RR_ARB8_BURST_EN lets a requester keep the grant for up to MAX_BURST beats.
module rr_arb8 #(
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy,
   output logic [2:0] last_winner
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
      $error("rr_arb8: MAX_BURST must be in 1..15");
   end

   logic [0:0] state;
   logic [2:0] ptr;
   logic [2:0] next_base;
   logic [3:0] win;
   logic       accept;
   logic       withdraw;
   logic       keep_burst;
   logic       rearb;

   // Returns {found, index} of the first set bit at or after base, wrapping 7 -> 0.
   function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] base);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0;
      for (int k = 7; k >= 0; k--) begin
         idx = base + 3'(k);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

`ifdef RR_ARB8_BURST_EN
   logic [3:0] burst_cnt;
`endif

   always_comb begin
      accept     = (state == GRANT) && out_valid && out_ready;
      withdraw   = (state == GRANT) && !out_ready && !req[sel];
      next_base  = (state == GRANT) ? sel + 3'd1 : ptr;
      win        = pick(req, next_base);
`ifdef RR_ARB8_BURST_EN
      keep_burst = accept && req[sel] && (burst_cnt < 4'(MAX_BURST));
`else
      keep_burst = 1'b0;
`endif
      rearb      = (state == IDLE) || ((accept || withdraw) && !keep_burst);
   end

   // A retired or withdrawn grant moves the pointer past itself and re-arbitrates in the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         gnt         <= 8'h00;
         sel         <= 3'd0;
         out_valid   <= 1'b0;
         ptr         <= 3'd0;
         last_winner <= 3'd7;
`ifdef RR_ARB8_BURST_EN
         burst_cnt   <= 4'd1;
`endif
      end else begin
         if (accept) last_winner <= sel;
         if ((state == GRANT) && rearb) ptr <= next_base;
         if (rearb) begin
            if (win[3]) begin
               state     <= GRANT;
               gnt       <= 8'b1 << win[2:0];
               sel       <= win[2:0];
               out_valid <= 1'b1;
`ifdef RR_ARB8_BURST_EN
               burst_cnt <= 4'd1;
`endif
            end else begin
               state     <= IDLE;
               gnt       <= 8'h00;
               out_valid <= 1'b0;
            end
         end
`ifdef RR_ARB8_BURST_EN
         else if (keep_burst) begin
            burst_cnt <= burst_cnt + 4'd1;
         end
`endif
      end
   end

   assign busy = (state == GRANT);

endmodule
